// File: rtl/usr_pkg.sv
// Shared encodings for the universal-shift-register sequencer: ops, datapath selects,
// FSM states and the default shift limit.
package usr_pkg;

    localparam int MAX_SHIFT_DEF = 8;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROTR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_SHR  = 2'b01,
        SEL_SHL  = 2'b10,
        SEL_LOAD = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Counts above the per-command limit are executed as the limit itself.
    function automatic logic [3:0] clamp_cnt(input logic [3:0] cnt, input int max_cnt);
        if (int'(cnt) > max_cnt) begin
            return 4'(max_cnt);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/usr8_dp.sv
// 8-bit universal shift register: hold, shift right, shift left, parallel load.
module usr8_dp
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  sel_e       select,
    input  logic [7:0] pload,
    input  logic       lftin,
    input  logic       rghtin,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 8'h00;
        end else begin
            unique case (select)
                SEL_HOLD: q <= q;
                SEL_SHR:  q <= {rghtin, q[7:1]};
                SEL_SHL:  q <= {q[6:0], lftin};
                SEL_LOAD: q <= pload;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/usr_seq_ctrl.sv
// Command sequencer driving usr8_dp. Define USR_SEQ_ROT_EN to execute ROTR;
// otherwise ROTR completes as a no-op.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_LOAD  | one cycle of parallel load with the latched data
// ST_SHIFT | shifting, one bit per cycle until the count expires
// ST_DONE  | one-cycle done pulse, register holds
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic [3:0] cmd_cnt,
    input  logic       sin,
    output logic [7:0] q,
    output logic       sout,
    output logic       busy,
    output logic       done
);

    state_e     state_q, state_d;
    op_e        op_q;
    logic [7:0] data_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_clamped;
    logic       accept;
    sel_e       sel;
    logic       lftin, rghtin;

    assign cnt_clamped = clamp_cnt(cmd_cnt, MAX_SHIFT);
    assign cmd_ready   = (state_q == ST_IDLE) && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            data_q  <= 8'h00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_e'(cmd_op);
                data_q <= cmd_data;
                cnt_q  <= cnt_clamped;
            end else if (state_q == ST_SHIFT) begin
                cnt_q  <= cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel     = SEL_HOLD;
        lftin   = 1'b0;
        rghtin  = 1'b0;
        sout    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op_e'(cmd_op))
                        OP_LOAD: state_d = ST_LOAD;
                        OP_ROTR: begin
`ifdef USR_SEQ_ROT_EN
                            state_d = (cnt_clamped == 4'd0) ? ST_DONE : ST_SHIFT;
`else
                            state_d = ST_DONE;
`endif
                        end
                        default: state_d = (cnt_clamped == 4'd0) ? ST_DONE : ST_SHIFT;
                    endcase
                end
            end
            ST_LOAD: begin
                sel     = SEL_LOAD;
                state_d = ST_DONE;
            end
            ST_SHIFT: begin
                unique case (op_q)
                    OP_SHR: begin
                        sel    = SEL_SHR;
                        rghtin = sin;
                        sout   = q[0];
                    end
                    OP_SHL: begin
                        sel   = SEL_SHL;
                        lftin = sin;
                        sout  = q[7];
                    end
                    OP_ROTR: begin
`ifdef USR_SEQ_ROT_EN
                        sel    = SEL_SHR;
                        rghtin = q[0];
                        sout   = q[0];
`endif
                    end
                    default: sel = SEL_HOLD;
                endcase
                // Terminal count: the cycle that applies the last shift leaves for DONE.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    usr8_dp u_dp (
        .clk    (clk),
        .rst    (rst),
        .select (sel),
        .pload  (data_q),
        .lftin  (lftin),
        .rghtin (rghtin),
        .q      (q)
    );

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Self-checking bench for usr_seq_ctrl: per-cycle comparison against a command-level
// model plus directed commands with literal final values and latencies.
module tb_usr_seq_ctrl;

    localparam int MAX_SHIFT = 8;
`ifdef USR_SEQ_ROT_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] cmd_cnt = 4'd0;
    logic       sin = 1'b0;
    logic [7:0] q;
    logic       sout, busy, done;

    int checks = 0;
    int errors = 0;

    usr_seq_ctrl #(.MAX_SHIFT(MAX_SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .sin       (sin),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- command-level model ----------------
    bit         m_active = 1'b0;
    int         m_k = 0;
    int         m_lat = 0;
    int         m_n = 0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_start = 8'h00;
    logic [7:0] m_q = 8'h00;
    logic       m_s = 1'b0;

    function automatic logic [7:0] shifted(input logic [1:0] op, input logic [7:0] v,
                                           input int j, input logic s);
        logic [15:0] t;
        case (op)
            2'b01:   begin t = {(s ? 8'hFF : 8'h00), v}; t = t >> j; return t[7:0];  end
            2'b10:   begin t = {v, (s ? 8'hFF : 8'h00)}; t = t << j; return t[15:8]; end
            2'b11:   begin t = {v, v};                   t = t >> j; return t[7:0];  end
            default: return v;
        endcase
    endfunction

    function automatic int latency(input logic [1:0] op, input int n);
        if (op == 2'b00) return 2;
        if (op == 2'b11 && !ROT_EN) return 1;
        if (n == 0) return 1;
        return n + 1;
    endfunction

    // Register value seen in cycle k after acceptance.
    function automatic logic [7:0] q_in_cycle(input int k);
        int j;
        if (m_op == 2'b00) return (k >= 2) ? m_data : m_start;
        if (m_op == 2'b11 && !ROT_EN) return m_start;
        j = (k - 1 < m_n) ? k - 1 : m_n;
        return shifted(m_op, m_start, j, m_s);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_q      <= 8'h00;
        end else if (!m_active) begin
            if (cmd_valid) begin
                int n;
                n = (int'(cmd_cnt) > MAX_SHIFT) ? MAX_SHIFT : int'(cmd_cnt);
                m_active <= 1'b1;
                m_k      <= 1;
                m_op     <= cmd_op;
                m_data   <= cmd_data;
                m_start  <= m_q;
                m_s      <= sin;
                m_n      <= n;
                m_lat    <= latency(cmd_op, n);
            end
        end else if (m_k >= m_lat) begin
            m_active <= 1'b0;
            m_q      <= q_in_cycle(m_lat);
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] eq;
        logic       es;
        eq = m_active ? q_in_cycle(m_k) : m_q;
        es = 1'b0;
        if (m_active && m_k <= m_n && m_op != 2'b00 && !(m_op == 2'b11 && !ROT_EN))
            es = (m_op == 2'b10) ? eq[7] : eq[0];
        check("cyc_q",     {24'd0, q},   {24'd0, eq});
        check("cyc_done",  {31'd0, done}, {31'd0, (m_active && m_k == m_lat)});
        check("cyc_busy",  {31'd0, busy}, {31'd0, m_active});
        check("cyc_ready", {31'd0, cmd_ready}, {31'd0, (!m_active && !rst)});
        check("cyc_sout",  {31'd0, sout}, {31'd0, es});
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(input string name, input logic [7:0] exp_q, input int exp_lat);
        int lat = 0;
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) got = 1'b1;
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_q"}, {24'd0, q}, {24'd0, exp_q});
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic [3:0] cnt,
                         input logic s);
        int w = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        sin       = s;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        // Scramble command inputs after acceptance; they must have no effect.
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_data  = ~data;
        cmd_cnt   = ~cnt;
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] data,
                           input logic [3:0] cnt, input logic s,
                           input logic [7:0] exp_q, input int exp_lat);
        issue(op, data, cnt, s);
        wait_done(name, exp_q, exp_lat);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_q", {24'd0, q}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_cmd("load_a5", 2'b00, 8'hA5, 4'd0, 1'b0, 8'hA5, 2);
        run_cmd("shr2_s1", 2'b01, 8'h00, 4'd2, 1'b1, 8'hE9, 3);
        run_cmd("load_a5b", 2'b00, 8'hA5, 4'd0, 1'b0, 8'hA5, 2);
        run_cmd("shl3_s0", 2'b10, 8'h00, 4'd3, 1'b0, 8'h28, 4);
        run_cmd("load_a5c", 2'b00, 8'hA5, 4'd0, 1'b0, 8'hA5, 2);
        run_cmd("shr12_clamp", 2'b01, 8'h00, 4'd12, 1'b0, 8'h00, 9);
        run_cmd("load_a5d", 2'b00, 8'hA5, 4'd0, 1'b0, 8'hA5, 2);
        if (ROT_EN) run_cmd("rotr4", 2'b11, 8'h00, 4'd4, 1'b0, 8'h5A, 5);
        else        run_cmd("rotr_noop", 2'b11, 8'h00, 4'd4, 1'b0, 8'hA5, 1);
        run_cmd("load_a5e", 2'b00, 8'hA5, 4'd0, 1'b0, 8'hA5, 2);
        run_cmd("shl_cnt0", 2'b10, 8'h00, 4'd0, 1'b1, 8'hA5, 1);
        run_cmd("shr_cnt0", 2'b01, 8'h00, 4'd0, 1'b1, 8'hA5, 1);
        run_cmd("shl8_s1", 2'b10, 8'h00, 4'd8, 1'b1, 8'hFF, 9);
        run_cmd("shr1_s0", 2'b01, 8'h00, 4'd1, 1'b0, 8'h7F, 2);

        // Reset in the middle of an 8-bit shift aborts it with no done pulse.
        issue(2'b01, 8'h00, 4'd8, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_q", {24'd0, q}, 32'h00);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 8'h3C;
        #1;
        check("postrst_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done("postrst_load", 8'h3C, 2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/usr_seq_ctrl.md
USR_SEQ_CTRL -- requirements
Module: usr_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_SHIFT, default 8: the largest shift/rotate count executed per command.
REQ-002 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1: a command is presented.
REQ-005 SHALL have port cmd_ready, output, 1: the controller can accept a command.
REQ-006 SHALL have port cmd_op, input, 2: 00 LOAD, 01 SHR, 10 SHL, 11 ROTR.
REQ-007 SHALL have port cmd_data, input, 8: parallel-load value, used by LOAD only.
REQ-008 SHALL have port cmd_cnt, input, 4: shift/rotate count for SHR/SHL/ROTR.
REQ-009 SHALL have port sin, input, 1: serial fill bit, sampled every shift cycle.
REQ-010 SHALL have port q, output, 8: register contents.
REQ-011 SHALL have port sout, output, 1: combinational q[0] during SHR/ROTR, q[7] during SHL, 0 otherwise.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-014 SHALL drive the datapath with select codes: 00 hold; 01 shift right (rghtin into bit 7); 10 shift left (lftin into bit 0); 11 parallel load.
REQ-015 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-016 SHALL assert cmd_ready only in IDLE with rst low; a command is accepted on a rising edge where cmd_valid && cmd_ready.
REQ-017 SHALL latch op, data and the count at acceptance; input changes after acceptance have no effect.
REQ-018 On LOAD acceptance SHALL go IDLE->LOAD, apply select 11 with the latched data for one cycle, then go to DONE.
REQ-019 On SHR/SHL/ROTR acceptance SHALL go IDLE->SHIFT and apply the shift select for exactly the latched count cycles, then go to DONE.
REQ-020 SHR SHALL fill from sin; SHL SHALL fill from sin; ROTR SHALL feed q[0] back into bit 7.
REQ-021 A count of 0 SHALL go IDLE->DONE directly, leaving q unchanged.
REQ-022 A count above MAX_SHIFT SHALL be clamped to MAX_SHIFT.
REQ-023 DONE SHALL last one cycle with done=1 and select 00, then return to IDLE; back-to-back commands thus have at least one idle cycle between them.
REQ-024 Latency from acceptance edge to done high SHALL be 2 cycles for LOAD and count+1 cycles for shifts.
REQ-025 In IDLE and DONE, q SHALL hold.

Reset
REQ-026 While rst is high, SHALL force q=0x00, state IDLE, done=0, busy=0, select 00, count register 0.
REQ-027 Reset mid-command SHALL abort the command without a done pulse; the first accept is possible on the first rising edge after rst falls.

Configuration
REQ-028 With macro USR_SEQ_ROT_EN defined, SHALL execute ROTR per REQ-020.
REQ-029 Without USR_SEQ_ROT_EN, cmd_op 11 SHALL be accepted as a no-op: IDLE->DONE, q unchanged, done after 1 cycle.

Structure
REQ-030 SHALL place the op encodings, select encodings, state enum and the MAX_SHIFT default in the shared package usr_pkg.
REQ-031 SHALL instantiate a single datapath sub-module, usr8_dp (8-bit universal shift register, ports select/pload/lftin/rghtin/q, clk, rst), and keep all sequencing in usr_seq_ctrl.

Verification
REQ-032 Bench SHALL cover: LOAD cmd_data=0xA5 -> q=0xA5, done high 2 cycles after acceptance.
REQ-033 Bench SHALL cover: from 0xA5, SHR cnt=2 sin=1 -> q=0xE9, done after 3 cycles.
REQ-034 Bench SHALL cover: from 0xA5, SHL cnt=3 sin=0 -> q=0x28; and SHR cnt=12 sin=0 clamped to 8 -> q=0x00.
REQ-035 Bench SHALL cover: with USR_SEQ_ROT_EN, from 0xA5, ROTR cnt=4 -> q=0x5A; without it, q stays 0xA5 and done follows after 1 cycle.
REQ-036 Bench SHALL cover: cnt=0 -> q unchanged, done on the next cycle.
REQ-037 Bench SHALL cover: rst pulsed during SHIFT of a cnt=8 command -> q=0x00, no done, cmd_ready high after rst falls.
